execute_stage: RTL
==================

# execute_stage

RV32I execute stage with its EX/MA pipeline register. Takes decoded operands from decode, resolves operand forwarding, computes the ALU result and branch/jump outcome, and registers everything the memory-access stage consumes (`i_ex_*`). Sequential duties:
- stall hold;
- flush bubbles;
- a registered redirect pulse to fetch;
- a squash counter that kills wrong-path instructions after a taken branch or jump.

## Interface
Parameters:
- KILL_SLOTS, 2, number of younger instructions converted to bubbles after a taken redirect (1..3).

Ports:
- i_clk  in  1  single clock; all state updates on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_clk_en  in  1  stage advance; 0 = stall (hold all state).
- i_flush  in  1  external flush; captures a bubble.
- i_id_valid  in  1  decode slot holds a real instruction.
- i_id_pc, i_id_pc_plus_4  in  32  instruction PC, PC+4.
- i_id_rs1_data, i_id_rs2_data  in  32  register-file read data.
- i_id_rs1, i_id_rs2, i_id_reg_dest  in  5  source/dest register indices.
- i_id_imm  in  32  sign-extended immediate.
- i_id_alu_op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B (LUI), 11 PC_ADD (AUIPC); others give 0.
- i_id_alu_src  in  1  operand B: 0 = rs2, 1 = imm.
- i_id_branch, i_id_jal, i_id_jalr  in  1  control-flow class.
- i_id_mem_rd, i_id_mem_wr, i_id_mem_to_reg, i_id_reg_wr  in  1  passthrough controls.
- i_id_rw_sel  in  2  passthrough writeback select.
- i_id_funct3  in  3;  i_id_funct7  in  7  passthrough, funct3 also branch condition.
- i_ma_result  in  32;  i_ma_reg_dest  in  5;  i_ma_reg_wr  in  1  forwarding from MA.
- i_wb_data  in  32;  i_wb_reg_dest  in  5;  i_wb_reg_wr  in  1  forwarding from WB.
- o_ex_mem_to_reg, o_ex_reg_wr, o_ex_mem_rd, o_ex_mem_wr  out  1  registered controls.
- o_ex_rw_sel  out  2;  o_ex_funct3  out  3;  o_ex_funct7  out  7;  o_ex_reg_dest  out  5.
- o_ex_pc_plus_4, o_ex_alu_result, o_ex_reg_read_data2  out  32  registered (data2 = forwarded rs2).
- o_ex_pc_sel  out  1  one-cycle redirect pulse.
- o_ex_branch_target  out  32  redirect address, valid while o_ex_pc_sel = 1.

## Operation
- Operand A = forwarded rs1 (PC for PC_ADD). Operand B = imm if alu_src, else forwarded rs2.
- Shifts use B[4:0]. SLT is signed, SLTU unsigned. All arithmetic is modulo 2^32.
- Branch conditions by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; others are not taken.
- Targets:
  - branch and JAL: pc + imm;
  - JALR: (rs1 + imm) with bit 0 cleared.
- Redirect is taken when the instruction is live and (jal | jalr | branch taken).
- Live = i_id_valid & !i_flush & squash counter == 0.
- Capture cycle (i_clk_en = 1):
  - Live instruction: register all outputs from the computed values.
  - Not live: capture a bubble with reg_wr, mem_rd, mem_wr and pc_sel = 0; data fields still load.
- o_ex_pc_sel is set only by a live taken redirect and cleared on every other edge, including stall edges.
- Squash counter:
  - Loads KILL_SLOTS on a live taken redirect.
  - Decrements by 1 on each capture while nonzero.
  - Holds during stall.
  - Clears on i_flush.

## Timing
- Latency: 1 cycle, decode inputs to registered `o_ex_*`.
- Redirect pulse appears the cycle after capture. The next KILL_SLOTS captured instructions become bubbles.
- Reset (i_rst_n = 0 at edge): every output is 0, squash counter is 0. This takes priority over clk_en and flush, and a mid-squash reset abandons the squash.
- Stall: all registers hold except o_ex_pc_sel, which drops to 0.
- i_flush with i_clk_en = 1 gives a bubble and clears the counter. i_flush with i_clk_en = 0 is ignored.
- Forwarding priority: MA over WB over register file. Never forward for index 0 (rs == 0 always reads the register-file value).
- Load-use hazards are handled by the hazard unit through i_clk_en and i_flush, not here.

## Configuration
- EX_FORWARD_EN defined: MA/WB forwarding muxes are compiled in, as described above.
- Undefined: operands come straight from i_id_rs1_data and i_id_rs2_data. The i_ma_* and i_wb_* ports remain but are unused.

## Test plan
- ADD x3: rs1 = 5, rs2 = 7, alu_src = 0 -> next cycle o_ex_alu_result = 12, o_ex_reg_wr = 1, o_ex_reg_dest = 3.
- EX_FORWARD_EN: rs1 = x4, i_ma_reg_dest = 4 with i_ma_result = 100, also i_wb_reg_dest = 4 with i_wb_data = 55, ADDI imm 1 -> result 101. Same with rs1 = x0 and MA dest 0 -> uses register-file value.
- BEQ at pc 0x40, rs1 = rs2 = 9, imm = 0x20 -> o_ex_pc_sel = 1 for exactly 1 cycle, target 0x60. The next 2 valid instructions give reg_wr = mem_wr = 0. The third passes.
- JALR, rs1 = 0x1001, imm = 4 -> target 0x1004. Stall for 3 cycles after capture -> pc_sel high 1 cycle only, all other outputs held.
- Valid SW with i_flush = 1 -> o_ex_mem_wr = 0. Next SW without flush -> mem_wr = 1, o_ex_reg_read_data2 = rs2 value.
- Taken branch, then i_rst_n = 0 one cycle into the squash -> all outputs 0. The first valid instruction after reset passes unsquashed.

Source files
------------

// File: rtl/execute_stage_if.sv
// Decode operands, MA/WB forwarding sources and EX/MA register outputs
// of execute_stage, grouped as one bundle.
interface execute_stage_if;
  logic        i_id_valid;
  logic [31:0] i_id_pc;
  logic [31:0] i_id_pc_plus_4;
  logic [31:0] i_id_rs1_data;
  logic [31:0] i_id_rs2_data;
  logic [4:0]  i_id_rs1;
  logic [4:0]  i_id_rs2;
  logic [4:0]  i_id_reg_dest;
  logic [31:0] i_id_imm;
  logic [3:0]  i_id_alu_op;
  logic        i_id_alu_src;
  logic        i_id_branch;
  logic        i_id_jal;
  logic        i_id_jalr;
  logic        i_id_mem_rd;
  logic        i_id_mem_wr;
  logic        i_id_mem_to_reg;
  logic        i_id_reg_wr;
  logic [1:0]  i_id_rw_sel;
  logic [2:0]  i_id_funct3;
  logic [6:0]  i_id_funct7;
  logic [31:0] i_ma_result;
  logic [4:0]  i_ma_reg_dest;
  logic        i_ma_reg_wr;
  logic [31:0] i_wb_data;
  logic [4:0]  i_wb_reg_dest;
  logic        i_wb_reg_wr;
  logic        o_ex_mem_to_reg;
  logic        o_ex_reg_wr;
  logic        o_ex_mem_rd;
  logic        o_ex_mem_wr;
  logic [1:0]  o_ex_rw_sel;
  logic [2:0]  o_ex_funct3;
  logic [6:0]  o_ex_funct7;
  logic [4:0]  o_ex_reg_dest;
  logic [31:0] o_ex_pc_plus_4;
  logic [31:0] o_ex_alu_result;
  logic [31:0] o_ex_reg_read_data2;
  logic        o_ex_pc_sel;
  logic [31:0] o_ex_branch_target;

  modport master (
    output i_id_valid, i_id_pc, i_id_pc_plus_4,
    output i_id_rs1_data, i_id_rs2_data,
    output i_id_rs1, i_id_rs2, i_id_reg_dest,
    output i_id_imm, i_id_alu_op, i_id_alu_src,
    output i_id_branch, i_id_jal, i_id_jalr,
    output i_id_mem_rd, i_id_mem_wr,
    output i_id_mem_to_reg, i_id_reg_wr,
    output i_id_rw_sel, i_id_funct3, i_id_funct7,
    output i_ma_result, i_ma_reg_dest, i_ma_reg_wr,
    output i_wb_data, i_wb_reg_dest, i_wb_reg_wr,
    input  o_ex_mem_to_reg, o_ex_reg_wr,
    input  o_ex_mem_rd, o_ex_mem_wr,
    input  o_ex_rw_sel, o_ex_funct3, o_ex_funct7,
    input  o_ex_reg_dest, o_ex_pc_plus_4,
    input  o_ex_alu_result, o_ex_reg_read_data2,
    input  o_ex_pc_sel, o_ex_branch_target
  );

  modport slave (
    input  i_id_valid, i_id_pc, i_id_pc_plus_4,
    input  i_id_rs1_data, i_id_rs2_data,
    input  i_id_rs1, i_id_rs2, i_id_reg_dest,
    input  i_id_imm, i_id_alu_op, i_id_alu_src,
    input  i_id_branch, i_id_jal, i_id_jalr,
    input  i_id_mem_rd, i_id_mem_wr,
    input  i_id_mem_to_reg, i_id_reg_wr,
    input  i_id_rw_sel, i_id_funct3, i_id_funct7,
    input  i_ma_result, i_ma_reg_dest, i_ma_reg_wr,
    input  i_wb_data, i_wb_reg_dest, i_wb_reg_wr,
    output o_ex_mem_to_reg, o_ex_reg_wr,
    output o_ex_mem_rd, o_ex_mem_wr,
    output o_ex_rw_sel, o_ex_funct3, o_ex_funct7,
    output o_ex_reg_dest, o_ex_pc_plus_4,
    output o_ex_alu_result, o_ex_reg_read_data2,
    output o_ex_pc_sel, o_ex_branch_target
  );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: forwarding, ALU, branch resolve, EX/MA register.
// Define EX_FORWARD_EN to compile in the MA/WB forwarding muxes.
module execute_stage #(
  parameter int KILL_SLOTS = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_clk_en,
  input  logic           i_flush,
  execute_stage_if.slave bus
);
  localparam logic [1:0] KILL = 2'(KILL_SLOTS);

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu;
  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic [4:0]  shamt;
  logic        cond;
  logic        live;
  logic        redirect;
  logic [1:0]  kill_cnt;

`ifdef EX_FORWARD_EN
  // MA beats WB beats the register file; x0 is never forwarded.
  always_comb begin
    rs1_val = bus.i_id_rs1_data;
    if (bus.i_id_rs1 != 5'd0) begin
      if (bus.i_ma_reg_wr &&
          bus.i_ma_reg_dest == bus.i_id_rs1)
        rs1_val = bus.i_ma_result;
      else if (bus.i_wb_reg_wr &&
               bus.i_wb_reg_dest == bus.i_id_rs1)
        rs1_val = bus.i_wb_data;
    end
  end

  always_comb begin
    rs2_val = bus.i_id_rs2_data;
    if (bus.i_id_rs2 != 5'd0) begin
      if (bus.i_ma_reg_wr &&
          bus.i_ma_reg_dest == bus.i_id_rs2)
        rs2_val = bus.i_ma_result;
      else if (bus.i_wb_reg_wr &&
               bus.i_wb_reg_dest == bus.i_id_rs2)
        rs2_val = bus.i_wb_data;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.i_ma_result, bus.i_ma_reg_dest,
                        bus.i_ma_reg_wr, bus.i_wb_data,
                        bus.i_wb_reg_dest, bus.i_wb_reg_wr,
                        bus.i_id_rs1, bus.i_id_rs2};
  assign rs1_val = bus.i_id_rs1_data;
  assign rs2_val = bus.i_id_rs2_data;
`endif

  assign op_a  = (bus.i_id_alu_op == 4'd11) ? bus.i_id_pc : rs1_val;
  assign op_b  = bus.i_id_alu_src ? bus.i_id_imm : rs2_val;
  assign shamt = op_b[4:0];

  always_comb begin
    alu = '0;
    case (bus.i_id_alu_op)
      4'd0:    alu = op_a + op_b;
      4'd1:    alu = op_a - op_b;
      4'd2:    alu = op_a << shamt;
      4'd3:    alu = {31'd0, $signed(op_a) < $signed(op_b)};
      4'd4:    alu = {31'd0, op_a < op_b};
      4'd5:    alu = op_a ^ op_b;
      4'd6:    alu = op_a >> shamt;
      4'd7:    alu = $unsigned($signed(op_a) >>> shamt);
      4'd8:    alu = op_a | op_b;
      4'd9:    alu = op_a & op_b;
      4'd10:   alu = op_b;
      4'd11:   alu = op_a + op_b;
      default: alu = '0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (bus.i_id_funct3)
      3'b000:  cond = rs1_val == rs2_val;
      3'b001:  cond = rs1_val != rs2_val;
      3'b100:  cond = $signed(rs1_val) < $signed(rs2_val);
      3'b101:  cond = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  cond = rs1_val < rs2_val;
      3'b111:  cond = rs1_val >= rs2_val;
      default: cond = 1'b0;
    endcase
  end

  assign jalr_sum = rs1_val + bus.i_id_imm;
  assign target   = bus.i_id_jalr ? {jalr_sum[31:1], 1'b0}
                                  : bus.i_id_pc + bus.i_id_imm;
  assign live     = bus.i_id_valid & ~i_flush & (kill_cnt == 2'd0);
  assign redirect = live & (bus.i_id_jal | bus.i_id_jalr |
                            (bus.i_id_branch & cond));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bus.o_ex_mem_to_reg     <= 1'b0;
      bus.o_ex_reg_wr         <= 1'b0;
      bus.o_ex_mem_rd         <= 1'b0;
      bus.o_ex_mem_wr         <= 1'b0;
      bus.o_ex_rw_sel         <= '0;
      bus.o_ex_funct3         <= '0;
      bus.o_ex_funct7         <= '0;
      bus.o_ex_reg_dest       <= '0;
      bus.o_ex_pc_plus_4      <= '0;
      bus.o_ex_alu_result     <= '0;
      bus.o_ex_reg_read_data2 <= '0;
      bus.o_ex_pc_sel         <= 1'b0;
      bus.o_ex_branch_target  <= '0;
      kill_cnt                <= '0;
    end else begin
      bus.o_ex_pc_sel <= 1'b0;
      if (i_clk_en) begin
        bus.o_ex_mem_to_reg     <= bus.i_id_mem_to_reg;
        bus.o_ex_reg_wr         <= live & bus.i_id_reg_wr;
        bus.o_ex_mem_rd         <= live & bus.i_id_mem_rd;
        bus.o_ex_mem_wr         <= live & bus.i_id_mem_wr;
        bus.o_ex_rw_sel         <= bus.i_id_rw_sel;
        bus.o_ex_funct3         <= bus.i_id_funct3;
        bus.o_ex_funct7         <= bus.i_id_funct7;
        bus.o_ex_reg_dest       <= bus.i_id_reg_dest;
        bus.o_ex_pc_plus_4      <= bus.i_id_pc_plus_4;
        bus.o_ex_alu_result     <= alu;
        bus.o_ex_reg_read_data2 <= rs2_val;
        bus.o_ex_pc_sel         <= redirect;
        bus.o_ex_branch_target  <= target;
        if (i_flush)
          kill_cnt <= '0;
        else if (redirect)
          kill_cnt <= KILL;
        else if (kill_cnt != 2'd0)
          kill_cnt <= kill_cnt - 2'd1;
      end
    end
  end
endmodule
